host_command_initiator: RTL and testbench

HOST_COMMAND_INITIATOR -- requirements
Module: host_command_initiator

---
 rtl/host_command_initiator.sv | 223 ++++++++++++++++++++++
 tb/tb_host_command_initiator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/host_command_initiator.sv
// host_command_initiator
//   Sends one host command to the NPU as a short burst of items: the command
//   word, then 0..3 argument items. Optionally it then waits for a single
//   response item. Finishes with a one-cycle done_o pulse.
//
// Parameters
//   ITEM_w          item width
//   TIMEOUT_CYCLES  response wait limit in cycles (1..65535), timeout build only
//
// Build option
//   HOST_CMD_TIMEOUT_EN  when defined, WAIT_RSP gives up after TIMEOUT_CYCLES
//                        cycles and reports timeout_o with done_o. When it is
//                        not defined, WAIT_RSP waits forever and timeout_o is 0.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o  command handshake (ready only in IDLE)
//   cmd_word_i, cmd_args_i     command word and args (arg k at [k*ITEM_w +: ITEM_w])
//   cmd_arg_num_i, cmd_rsp_i   argument count 0..3, response expected
//   done_o, rsp_data_o         completion pulse, response item (0 if none)
//   timeout_o                  with done_o: response wait expired
//   spurious_o                 sticky: response item seen while not waiting
//   item_data_o/item_valid_o   item stream to NPU (transfer whenever valid)
//   item_avail_i               NPU can take an item this cycle
//   item_data_i/item_valid_i   response item from NPU
//   item_avail_o               initiator is waiting for a response
//
// State table
//   IDLE     | ready for a new command
//   SEND_CMD | emitting the command word
//   SEND_ARG | emitting argument idx_q
//   WAIT_RSP | waiting for the response item
//   DONE     | one-cycle completion pulse
module host_command_initiator #(
  parameter int ITEM_w         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ITEM_w-1:0]     cmd_word_i,
  input  logic [3*ITEM_w-1:0]   cmd_args_i,
  input  logic [1:0]            cmd_arg_num_i,
  input  logic                  cmd_rsp_i,
  output logic                  done_o,
  output logic [ITEM_w-1:0]     rsp_data_o,
  output logic                  timeout_o,
  output logic                  spurious_o,
  output logic [ITEM_w-1:0]     item_data_o,
  output logic                  item_valid_o,
  input  logic                  item_avail_i,
  input  logic [ITEM_w-1:0]     item_data_i,
  input  logic                  item_valid_i,
  output logic                  item_avail_o
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_ARG,
    WAIT_RSP,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ITEM_w-1:0]     word_q, word_d;
  logic [3*ITEM_w-1:0]   args_q, args_d;
  logic [1:0]            num_q, num_d;
  logic [1:0]            idx_q, idx_d;
  logic                  rspf_q, rspf_d;
  logic [ITEM_w-1:0]     rsp_data_q, rsp_data_d;
  logic                  spurious_q, spurious_d;
  logic [ITEM_w-1:0]     cur_item;
  logic                  sending;

`ifdef HOST_CMD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]           cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
`endif

  assign sending      = (state_q == SEND_CMD) || (state_q == SEND_ARG);
  assign cmd_ready_o  = (state_q == IDLE);
  assign item_valid_o = sending && item_avail_i;
  assign item_data_o  = item_valid_o ? cur_item : '0;
  assign item_avail_o = (state_q == WAIT_RSP);
  assign done_o       = (state_q == DONE);
  assign rsp_data_o   = rsp_data_q;
  assign spurious_o   = spurious_q;

  always_comb begin
    cur_item = word_q;
    if (state_q == SEND_ARG) begin
      case (idx_q)
        2'd0:    cur_item = args_q[ITEM_w-1:0];
        2'd1:    cur_item = args_q[2*ITEM_w-1:ITEM_w];
        default: cur_item = args_q[3*ITEM_w-1:2*ITEM_w];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    args_d     = args_q;
    num_d      = num_q;
    idx_d      = idx_q;
    rspf_d     = rspf_q;
    rsp_data_d = rsp_data_q;
    // Response items are only legal while waiting; anything else is flagged.
    spurious_d = spurious_q | (item_valid_i && (state_q != WAIT_RSP));
`ifdef HOST_CMD_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          word_d  = cmd_word_i;
          args_d  = cmd_args_i;
          num_d   = cmd_arg_num_i;
          rspf_d  = cmd_rsp_i;
          idx_d   = 2'd0;
          state_d = SEND_CMD;
        end
      end
      SEND_CMD: begin
        if (item_avail_i) begin
          if (num_q != 2'd0) begin
            idx_d   = 2'd0;
            state_d = SEND_ARG;
          end else if (rspf_q) begin
            state_d = WAIT_RSP;
          end else begin
            rsp_data_d = '0;
            state_d    = DONE;
          end
        end
      end
      SEND_ARG: begin
        if (item_avail_i) begin
          if (idx_q == num_q - 2'd1) begin
            if (rspf_q) begin
              state_d = WAIT_RSP;
            end else begin
              rsp_data_d = '0;
              state_d    = DONE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WAIT_RSP: begin
        // A response arriving in the expiry cycle takes priority.
        if (item_valid_i) begin
          rsp_data_d = item_data_i;
          state_d    = DONE;
        end
`ifdef HOST_CMD_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rsp_data_d = '0;
          timeout_d  = 1'b1;
          state_d    = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef HOST_CMD_TIMEOUT_EN
  // Counts cycles spent in WAIT_RSP; clears whenever the FSM leaves it.
  always_comb begin
    cnt_d = 16'd0;
    if ((state_q == WAIT_RSP) && (state_d == WAIT_RSP)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      args_q     <= '0;
      num_q      <= 2'd0;
      idx_q      <= 2'd0;
      rspf_q     <= 1'b0;
      rsp_data_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      args_q     <= args_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      rspf_q     <= rspf_d;
      rsp_data_q <= rsp_data_d;
      spurious_q <= spurious_d;
    end
  end

endmodule

// File: tb/tb_host_command_initiator.sv
module tb_host_command_initiator;

`ifdef HOST_CMD_TIMEOUT_EN
  localparam int TO       = 8;
  localparam int RSP_WAIT = 5;
  localparam logic [31:0] LAST_RD = 32'h77;
`else
  localparam int TO       = 1024;
  localparam int RSP_WAIT = 10;
  localparam logic [31:0] LAST_RD = 32'hCAFE;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i, cmd_ready_o, cmd_rsp_i;
  logic [31:0] cmd_word_i;
  logic [95:0] cmd_args_i;
  logic [1:0]  cmd_arg_num_i;
  logic        done_o, timeout_o, spurious_o;
  logic [31:0] rsp_data_o, item_data_o, item_data_i;
  logic        item_valid_o, item_avail_i, item_valid_i, item_avail_o;

  int errors = 0;
  int checks = 0;

  host_command_initiator #(.ITEM_w(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_word_i(cmd_word_i), .cmd_args_i(cmd_args_i),
    .cmd_arg_num_i(cmd_arg_num_i), .cmd_rsp_i(cmd_rsp_i),
    .done_o(done_o), .rsp_data_o(rsp_data_o), .timeout_o(timeout_o),
    .spurious_o(spurious_o),
    .item_data_o(item_data_o), .item_valid_o(item_valid_o),
    .item_avail_i(item_avail_i), .item_data_i(item_data_i),
    .item_valid_i(item_valid_i), .item_avail_o(item_avail_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cv;
    logic [31:0] word;
    logic [95:0] args;
    logic [1:0]  num;
    logic        rsp;
    logic        av;
    logic        iv;
    logic [31:0] id;
    logic        e_rdy;
    logic        e_ivo;
    logic [31:0] e_ido;
    logic        e_done;
    logic [31:0] e_rd;
    logic        e_to;
    logic        e_avo;
    logic        e_sp;
  } vec_t;

  function automatic vec_t mk(logic rst, logic cv, logic [31:0] word, logic [95:0] args,
                              logic [1:0] num, logic rsp, logic av, logic iv, logic [31:0] id,
                              logic e_rdy, logic e_ivo, logic [31:0] e_ido, logic e_done,
                              logic [31:0] e_rd, logic e_to, logic e_avo, logic e_sp);
    vec_t v;
    v.rst = rst; v.cv = cv; v.word = word; v.args = args; v.num = num; v.rsp = rsp;
    v.av = av; v.iv = iv; v.id = id;
    v.e_rdy = e_rdy; v.e_ivo = e_ivo; v.e_ido = e_ido; v.e_done = e_done;
    v.e_rd = e_rd; v.e_to = e_to; v.e_avo = e_avo; v.e_sp = e_sp;
    return v;
  endfunction

  // No new command offered this cycle.
  function automatic vec_t q(logic av, logic iv, logic [31:0] id,
                             logic e_rdy, logic e_ivo, logic [31:0] e_ido, logic e_done,
                             logic [31:0] e_rd, logic e_to, logic e_avo, logic e_sp);
    return mk(1'b0, 1'b0, 32'h0, 96'h0, 2'd0, 1'b0, av, iv, id,
              e_rdy, e_ivo, e_ido, e_done, e_rd, e_to, e_avo, e_sp);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    cmd_valid_i   = v.cv;
    cmd_word_i    = v.word;
    cmd_args_i    = v.args;
    cmd_arg_num_i = v.num;
    cmd_rsp_i     = v.rsp;
    item_avail_i  = v.av;
    item_valid_i  = v.iv;
    item_data_i   = v.id;
    #1;
    chk({tag, " cmd_ready"},  {31'b0, cmd_ready_o},  {31'b0, v.e_rdy});
    chk({tag, " item_valid"}, {31'b0, item_valid_o}, {31'b0, v.e_ivo});
    chk({tag, " item_data"},  item_data_o,           v.e_ido);
    chk({tag, " done"},       {31'b0, done_o},       {31'b0, v.e_done});
    chk({tag, " rsp_data"},   rsp_data_o,            v.e_rd);
    chk({tag, " timeout"},    {31'b0, timeout_o},    {31'b0, v.e_to});
    chk({tag, " item_avail"}, {31'b0, item_avail_o}, {31'b0, v.e_avo});
    chk({tag, " spurious"},   {31'b0, spurious_o},   {31'b0, v.e_sp});
  endtask

  localparam logic [95:0] A1 = {32'h0, 32'h800, 32'h400};
  localparam logic [95:0] A2 = {32'hC, 32'hB, 32'hA};

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_valid_i = 1'b0; cmd_word_i = '0; cmd_args_i = '0;
    cmd_arg_num_i = '0; cmd_rsp_i = 1'b0; item_avail_i = 1'b0;
    item_valid_i = 1'b0; item_data_i = '0;
    repeat (3) @(posedge clk);

    // Basic flows, cycle by cycle. First row also checks reset values.
    tbl[0]  = mk(0,1,32'h1,A1,2,0,1,0,0,   1,0,32'h0,0,32'h0,0,0,0);
    tbl[1]  = q(1,0,0,                      0,1,32'h1,0,32'h0,0,0,0);
    tbl[2]  = q(1,0,0,                      0,1,32'h400,0,32'h0,0,0,0);
    tbl[3]  = q(1,0,0,                      0,1,32'h800,0,32'h0,0,0,0);
    tbl[4]  = q(1,0,0,                      0,0,32'h0,1,32'h0,0,0,0);
    tbl[5]  = mk(0,1,32'h5,96'h0,0,1,1,0,0, 1,0,32'h0,0,32'h0,0,0,0);
    tbl[6]  = q(1,0,0,                      0,1,32'h5,0,32'h0,0,0,0);
    tbl[7]  = q(1,1,32'h1234,               0,0,32'h0,0,32'h0,0,1,0);
    tbl[8]  = q(1,0,0,                      0,0,32'h0,1,32'h1234,0,0,0);
    tbl[9]  = mk(0,1,32'h9,A2,3,0,0,0,0,    1,0,32'h0,0,32'h1234,0,0,0);
    tbl[10] = q(0,0,0,                      0,0,32'h0,0,32'h1234,0,0,0);
    tbl[11] = q(1,0,0,                      0,1,32'h9,0,32'h1234,0,0,0);
    tbl[12] = q(1,0,0,                      0,1,32'hA,0,32'h1234,0,0,0);
    tbl[13] = q(1,0,0,                      0,1,32'hB,0,32'h1234,0,0,0);
    tbl[14] = q(1,0,0,                      0,1,32'hC,0,32'h1234,0,0,0);
    tbl[15] = q(1,0,0,                      0,0,32'h0,1,32'h0,0,0,0);
    tbl[16] = q(0,0,0,                      1,0,32'h0,0,32'h0,0,0,0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Stall after the command word: arg 0 held, nothing lost or duplicated.
    apply("stall acc", mk(0,1,32'h1,A1,2,0,1,0,0, 1,0,32'h0,0,32'h0,0,0,0));
    apply("stall cmd", q(1,0,0, 0,1,32'h1,0,32'h0,0,0,0));
    for (int i = 0; i < 5; i++) apply("stall hold", q(0,0,0, 0,0,32'h0,0,32'h0,0,0,0));
    apply("stall a0",   q(1,0,0, 0,1,32'h400,0,32'h0,0,0,0));
    apply("stall a1",   q(1,0,0, 0,1,32'h800,0,32'h0,0,0,0));
    apply("stall done", q(1,0,0, 0,0,32'h0,1,32'h0,0,0,0));

    // Response after a wait.
    apply("rsp acc", mk(0,1,32'h5,96'h0,0,1,1,0,0, 1,0,32'h0,0,32'h0,0,0,0));
    apply("rsp cmd", q(1,0,0, 0,1,32'h5,0,32'h0,0,0,0));
    for (int i = 0; i < RSP_WAIT; i++) apply("rsp wait", q(1,0,0, 0,0,32'h0,0,32'h0,0,1,0));
    apply("rsp item", q(1,1,32'hCAFE, 0,0,32'h0,0,32'h0,0,1,0));
    apply("rsp done", q(1,0,0, 0,0,32'h0,1,32'hCAFE,0,0,0));
    apply("rsp idle", q(1,0,0, 1,0,32'h0,0,32'hCAFE,0,0,0));

`ifdef HOST_CMD_TIMEOUT_EN
    // No response: 8 WAIT_RSP cycles then timeout completion.
    apply("to acc", mk(0,1,32'h5,96'h0,0,1,1,0,0, 1,0,32'h0,0,32'hCAFE,0,0,0));
    apply("to cmd", q(1,0,0, 0,1,32'h5,0,32'hCAFE,0,0,0));
    for (int i = 0; i < 8; i++) apply("to wait", q(1,0,0, 0,0,32'h0,0,32'hCAFE,0,1,0));
    apply("to done", q(1,0,0, 0,0,32'h0,1,32'h0,1,0,0));
    apply("to idle", q(1,0,0, 1,0,32'h0,0,32'h0,0,0,0));
    // Response in the expiry cycle wins.
    apply("tw acc", mk(0,1,32'h5,96'h0,0,1,1,0,0, 1,0,32'h0,0,32'h0,0,0,0));
    apply("tw cmd", q(1,0,0, 0,1,32'h5,0,32'h0,0,0,0));
    for (int i = 0; i < 7; i++) apply("tw wait", q(1,0,0, 0,0,32'h0,0,32'h0,0,1,0));
    apply("tw item", q(1,1,32'h77, 0,0,32'h0,0,32'h0,0,1,0));
    apply("tw done", q(1,0,0, 0,0,32'h0,1,32'h77,0,0,0));
`endif

    // Spurious item in IDLE, then reset in the middle of SEND_ARG.
    apply("sp pulse", q(0,1,32'hDEAD, 1,0,32'h0,0,LAST_RD,0,0,0));
    apply("sp set",   q(0,0,0, 1,0,32'h0,0,LAST_RD,0,0,1));
    apply("sp stick", q(0,0,0, 1,0,32'h0,0,LAST_RD,0,0,1));
    apply("rst acc",  mk(0,1,32'h1,A1,2,0,1,0,0, 1,0,32'h0,0,LAST_RD,0,0,1));
    apply("rst cmd",  q(1,0,0, 0,1,32'h1,0,LAST_RD,0,0,1));
    apply("rst hit",  mk(1,0,32'h0,96'h0,0,0,1,0,0, 0,1,32'h400,0,LAST_RD,0,0,1));
    apply("rst after", q(1,0,0, 1,0,32'h0,0,32'h0,0,0,0));
    apply("rst idle",  q(1,0,0, 1,0,32'h0,0,32'h0,0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
